// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter plus frame sequencer that shares one
// idle-high serial TX line among 4 sources of 16-bit words.
// Frame: start bit 0, 16 data bits LSB first, STOP_BITS stop bits at 1.
// Optional macro SERIAL_TX_GAP_EN adds an idle-high guard gap of GAP_BITS bit
// periods after every frame so the receiver resynchronises on each word.
module serial_tx_arbiter #(
    parameter int FREQ_CLK  = 16_000_000,
    parameter int FREQ_BAUD = 1_000_000,
    parameter int PERIOD    = FREQ_CLK / FREQ_BAUD,
    parameter int STOP_BITS = 2,
    parameter int GAP_BITS  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] data_i,
    output logic [3:0]  ack,
    output logic        tx_o,
    output logic        busy,
    output logic [1:0]  grant_id
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

`ifdef SERIAL_TX_GAP_EN
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    grant_id_q, grant_id_d;
    logic [3:0]    ack_q, ack_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
`ifdef SERIAL_TX_GAP_EN
    logic [GW-1:0] gap_q, gap_d;
`endif

    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic          cnt_tc;

    // Round-robin search: first requesting source at or above the pointer, wrapping mod 4
    always_comb begin
        logic [1:0] idx;
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        idx        = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    assign cnt_tc = (cnt_q == CW'(PERIOD - 1));

    // Next-state logic: grant/latch in IDLE, then time each bit period of the frame
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        ack_d      = 4'b0000;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
`ifdef SERIAL_TX_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    shreg_d    = data_i[{pick_idx, 4'b0000} +: 16];
                    grant_id_d = pick_idx;
                    ack_d      = 4'b0001 << pick_idx;
                    ptr_d      = pick_idx + 2'd1;
                    cnt_d      = '0;
                    bit_d      = '0;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d = cnt_tc ? '0 : cnt_q + CW'(1);
                if (cnt_tc) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_tc ? '0 : cnt_q + CW'(1);
                if (cnt_tc) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 4'd15) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_tc ? '0 : cnt_q + CW'(1);
                if (cnt_tc) begin
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        bit_d = '0;
`ifdef SERIAL_TX_GAP_EN
                        state_d = GAP;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef SERIAL_TX_GAP_EN
            GAP: begin
                cnt_d = cnt_tc ? '0 : cnt_q + CW'(1);
                if (cnt_tc) begin
                    if (gap_q == GW'(GAP_BITS - 1)) begin
                        gap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
`ifdef SERIAL_TX_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
`ifdef SERIAL_TX_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    // Line level follows the state directly so reset forces it high at once
    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = shreg_q[0];
            default: tx_o = 1'b1;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign ack      = ack_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter at default parameters (16 clocks/bit,
// 2 stop bits, guard gap disabled). Inputs driven and outputs sampled on the
// falling clock edge.
module tb_serial_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] data_i;
    logic [3:0]  ack;
    logic        tx_o;
    logic        busy;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    serial_tx_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_i   (data_i),
        .ack      (ack),
        .tx_o     (tx_o),
        .busy     (busy),
        .grant_id (grant_id)
    );

    // 10 ns system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports tag, observed and expected on mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive request and data words on a falling edge
    task automatic applyStimulus(input logic [3:0] r, input logic [63:0] d);
        @(negedge clk);
        req    = r;
        data_i = d;
    endtask

    // Step falling edges until an ack shows up or the budget runs out
    task automatic waitAck(input int maxCycles, output int waited);
        waited = 0;
        while (ack === 4'b0000 && waited < maxCycles) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Called at the first frame cycle (ack visible); walks 304 cycles and
    // decodes the line at mid-bit like a receiver would
    task automatic captureFrame(output logic [15:0] word, output int startErr, output int stopErr,
                                output int busyCycles, output int ackCycles);
        int bitIdx;
        word       = '0;
        startErr   = 0;
        stopErr    = 0;
        busyCycles = 0;
        ackCycles  = 0;
        for (int c = 0; c < 304; c++) begin
            if (busy === 1'b1) busyCycles++;
            if (ack !== 4'b0000) ackCycles++;
            if (c < 16 && tx_o !== 1'b0) startErr++;
            if (c >= 16 && c < 272 && ((c - 16) % 16) == 8) begin
                bitIdx = (c - 16) / 16;
                word[bitIdx] = tx_o;
            end
            if (c >= 272 && tx_o !== 1'b1) stopErr++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          waited;
        int          startErr, stopErr, busyCycles, ackCycles;
        logic [15:0] word;
        int          rrOrder [5];
        logic [15:0] rrWords [4];
        logic [15:0] loopWords [3];

        rrOrder   = '{0, 1, 2, 3, 0};
        rrWords   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        loopWords = '{16'h0001, 16'hFFFE, 16'h8000};

        req    = 4'b0000;
        data_i = '0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx_o, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_grant", grant_id, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_tx", tx_o, 1);
        checkOutput("idle_busy", busy, 0);

        // All sources requesting from pointer 0: grants 0,1,2,3,0, starts 305 clocks apart
        applyStimulus(4'b1111, {rrWords[3], rrWords[2], rrWords[1], rrWords[0]});
        waitAck(4, waited);
        checkOutput("rr_first_latency", waited, 1);
        for (int n = 0; n < 5; n++) begin
            checkOutput("rr_ack", ack, 32'(4'b0001 << rrOrder[n]));
            checkOutput("rr_grant", grant_id, rrOrder[n]);
            if (n == 4) req = 4'b0000;
            captureFrame(word, startErr, stopErr, busyCycles, ackCycles);
            checkOutput("rr_word", word, rrWords[rrOrder[n]]);
            checkOutput("rr_busy_len", busyCycles, 304);
            checkOutput("rr_idle_gap_busy", busy, 0);
            @(negedge clk);
        end
        checkOutput("rr_no_extra_ack", ack, 0);
        checkOutput("rr_no_extra_tx", tx_o, 1);

        // Single word from source 0 (pointer now 1, search wraps to 0)
        applyStimulus(4'b0001, {48'h0, 16'hA5C3});
        waitAck(4, waited);
        checkOutput("single_latency", waited, 1);
        checkOutput("single_ack", ack, 4'b0001);
        checkOutput("single_tx_fall", tx_o, 0);
        checkOutput("single_busy", busy, 1);
        checkOutput("single_grant", grant_id, 0);
        req = 4'b0000;
        captureFrame(word, startErr, stopErr, busyCycles, ackCycles);
        checkOutput("single_word", word, 16'hA5C3);
        checkOutput("single_start", startErr, 0);
        checkOutput("single_stop", stopErr, 0);
        checkOutput("single_busy_len", busyCycles, 304);
        checkOutput("single_ack_len", ackCycles, 1);
        checkOutput("single_end_busy", busy, 0);
        checkOutput("single_end_tx", tx_o, 1);

        // Fairness: grant to 2, then req 0101 gives 0 then 2
        applyStimulus(4'b0100, 64'h0000_5555_0000_0000);
        waitAck(4, waited);
        checkOutput("fair_first_ack", ack, 4'b0100);
        checkOutput("fair_first_grant", grant_id, 2);
        req    = 4'b0101;
        data_i = 64'h0000_5555_0000_AAAA;
        captureFrame(word, startErr, stopErr, busyCycles, ackCycles);
        checkOutput("fair_first_word", word, 16'h5555);
        @(negedge clk);
        checkOutput("fair_second_ack", ack, 4'b0001);
        checkOutput("fair_second_grant", grant_id, 0);
        captureFrame(word, startErr, stopErr, busyCycles, ackCycles);
        checkOutput("fair_second_word", word, 16'hAAAA);
        @(negedge clk);
        checkOutput("fair_third_ack", ack, 4'b0100);
        checkOutput("fair_third_grant", grant_id, 2);
        req = 4'b0000;
        captureFrame(word, startErr, stopErr, busyCycles, ackCycles);

        // Loopback-style decode of edge-case words from source 3
        for (int n = 0; n < 3; n++) begin
            applyStimulus(4'b1000, {loopWords[n], 48'h0});
            waitAck(4, waited);
            checkOutput("loop_ack", ack, 4'b1000);
            req = 4'b0000;
            captureFrame(word, startErr, stopErr, busyCycles, ackCycles);
            checkOutput("loop_word", word, loopWords[n]);
            checkOutput("loop_start", startErr, 0);
            checkOutput("loop_stop", stopErr, 0);
        end

        // Asynchronous reset at clock 100 of a frame
        applyStimulus(4'b0100, 64'h0000_7E7E_0000_0000);
        waitAck(4, waited);
        checkOutput("areset_pre_ack", ack, 4'b0100);
        req = 4'b0000;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_tx", tx_o, 1);
        checkOutput("areset_busy", busy, 0);
        checkOutput("areset_ack", ack, 0);
        checkOutput("areset_grant", grant_id, 0);
        repeat (2) @(negedge clk);
        req    = 4'b0010;
        data_i = 64'h0000_0000_BEEF_0000;
        rst_n  = 1'b1;
        waitAck(4, waited);
        checkOutput("areset_latency", waited, 1);
        checkOutput("areset_new_ack", ack, 4'b0010);
        checkOutput("areset_new_grant", grant_id, 1);
        checkOutput("areset_new_tx", tx_o, 0);
        req = 4'b0000;
        captureFrame(word, startErr, stopErr, busyCycles, ackCycles);
        checkOutput("areset_new_word", word, 16'hBEEF);
        checkOutput("areset_new_busy_len", busyCycles, 304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
